// File: rtl/uart_echo_initiator.sv
// uart_echo_initiator
// Drives a UART loopback self-test. Once a run is started it sends a sequence
// of incrementing bytes through uart_tx, waits for each echo from uart_rx and
// checks that the echo equals the sent byte plus one (mod 256). Mismatches are
// counted, and a missing echo aborts the run with timeout set.
//
// Ports
//   clk        system clock, all logic on rising edge
//   rst        synchronous active-high reset
//   start      one-cycle run request (only honoured in IDLE)
//   seed       first byte of the run, sampled with start
//   count      number of transactions, sampled with start
//   tx_data    byte presented to uart_tx
//   tx_start   one-cycle transmit strobe to uart_tx
//   tx_busy    uart_tx busy flag
//   rx_data    byte from uart_rx
//   rx_valid   uart_rx valid level (may stay high several cycles)
//   busy       run in progress
//   done       one-cycle pulse at end of run
//   pass       run result, valid from done until next accepted start
//   timeout    run aborted on a missing echo
//   err_count  mismatched echoes, saturating at 255
//   last_rx    most recent echo captured in WAIT_RX
module uart_echo_initiator #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] count,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_count,
  output logic [7:0] last_rx
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_RX = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [7:0]    remaining;
  logic [TW-1:0] tmo_cnt;
  logic          rx_valid_d;
  logic          rx_edge;

  // rx_valid is a level; only its rising edge marks a new echo.
  assign rx_edge = rx_valid & ~rx_valid_d;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      last_rx    <= '0;
      remaining  <= '0;
      tmo_cnt    <= '0;
      rx_valid_d <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      tx_start   <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_data   <= seed;
            remaining <= count;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            state     <= (count == 8'd0) ? DONE : SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tmo_cnt  <= '0;
            state    <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          // An echo arriving on the last allowed cycle still counts.
          if (rx_edge) begin
            last_rx <= rx_data;
            state   <= CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        CHECK: begin
          // Expected echo wraps: 0xFF is answered by 0x00.
          if ((last_rx != 8'(tx_data + 8'd1)) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
            state <= DONE;
          end else begin
            tx_data <= tx_data + 8'd1;
            state   <= SEND;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == 8'd0) && !timeout;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_initiator.sv
// Testbench for uart_echo_initiator: randomized loopback runs with a
// scoreboard of expected transmitted bytes and end-of-run results.
module tb_uart_echo_initiator;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] count = '0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       busy, done, pass, timeout;
  logic [7:0] err_count, last_rx;

  uart_echo_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .count(count),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count), .last_rx(last_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       p;
    logic       t;
    logic [7:0] e;
    logic [7:0] l;
  } res_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tx_cnt = 0, tx_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [7:0] tx_q[$];
  res_t       res_q[$];
  logic [7:0] last_model = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents tx_start or done.
  always @(negedge clk) begin
    res_t r;
    if (!rst && tx_start) begin
      tx_cnt++;
      tx_cyc = cyc;
      if (tx_q.size() == 0) flag("unexpected tx_start");
      else begin
        chk("tx_data", tx_data, tx_q.pop_front());
        chk("busy at tx_start", busy, 1);
      end
    end
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
      if (res_q.size() == 0) flag("unexpected done");
      else begin
        r = res_q.pop_front();
        chk("pass", pass, r.p);
        chk("timeout", timeout, r.t);
        chk("err_count", err_count, r.e);
        chk("last_rx", last_rx, r.l);
        chk("busy at done", busy, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int target, output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int k = 0; k < 400; k++) begin
      if (tx_cnt >= target) begin ok = 1'b1; c = tx_cyc; break; end
      @(negedge clk); #1;
    end
    if (!ok) flag("wait tx_start budget expired");
  endtask

  task automatic wait_done(input int target, output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int k = 0; k < 400; k++) begin
      if (done_cnt >= target) begin ok = 1'b1; c = done_cyc; break; end
      @(negedge clk); #1;
    end
    if (!ok) flag("wait done budget expired");
  endtask

  // mode: 0 echo byte+1, 1 echo byte unchanged, 2 occasional corruption.
  // drop: index of the byte that never gets echoed (-1 none).
  task automatic do_run(input logic [7:0] sd, input int cnt, input int mode,
                        input int drop, input bit stray_in, input bit nobusy,
                        input bit ign, input int fixd, input int fixh);
    logic [7:0] ev [256];
    int dl [256];
    int hl [256];
    int ntx, necho, err, s_cyc, tc, ec, dc, tx_base, done_base, bend, tend;
    bit tmo, ok, stray;
    res_t r;
    stray = stray_in && !nobusy;
    tc = 0; ec = 0;
    for (int i = 0; i < cnt; i++) begin
      logic [7:0] exp;
      exp = 8'(sd + i + 1);
      case (mode)
        0:       ev[i] = exp;
        1:       ev[i] = 8'(sd + i);
        default: ev[i] = ($urandom_range(3) == 0) ? (exp ^ 8'($urandom_range(1, 255))) : exp;
      endcase
      dl[i] = (fixd != 0) ? fixd : int'($urandom_range(4, 50));
      hl[i] = (fixh != 0) ? fixh : (nobusy ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 5)));
    end
    // Reference model of the whole run.
    tmo   = (drop >= 0) && (drop < cnt);
    ntx   = tmo ? drop + 1 : cnt;
    necho = tmo ? drop : cnt;
    err = 0;
    for (int i = 0; i < necho; i++) if (ev[i] != 8'(sd + i + 1)) err++;
    if (necho > 0) last_model = ev[necho-1];
    r.p = (err == 0) && !tmo;
    r.t = tmo;
    r.e = (err > 255) ? 8'hFF : 8'(err);
    r.l = last_model;
    for (int i = 0; i < ntx; i++) tx_q.push_back(8'(sd + i));
    res_q.push_back(r);
    tx_base   = tx_cnt;
    done_base = done_cnt;

    tick(); start = 1'b1; seed = sd; count = 8'(cnt); s_cyc = cyc;
    tick(); start = 1'b0; seed = 8'($urandom); count = 8'($urandom);

    for (int i = 0; i < ntx; i++) begin
      wait_tx(tx_base + i + 1, tc, ok);
      if (!ok) return;
      if (i == 0) chk("start to tx_start latency", tc - s_cyc, 2);
      else if (nobusy) chk("echo to tx_start latency", tc - ec, 3);
      if (i == drop) begin
        for (int t = 1; t <= 3; t++) begin
          tick();
          tx_busy = (t < 3);
          start = ign && (t == 1);
          if (start) begin seed = 8'($urandom); count = 8'($urandom); end
        end
      end else begin
        bend = nobusy ? 0 : int'($urandom_range(dl[i] + hl[i] + 1 + int'(stray), dl[i] + hl[i] + 8));
        tend = (bend != 0) ? bend + 1 : dl[i] + hl[i];
        for (int t = 1; t <= tend; t++) begin
          tick();
          tx_busy = (t <= bend);
          if (t == dl[i]) begin rx_data = ev[i]; ec = cyc; end
          if (stray && t == dl[i] + hl[i] + 1) rx_data = 8'($urandom);
          rx_valid = (t >= dl[i] && t < dl[i] + hl[i]) || (stray && t == dl[i] + hl[i] + 1);
          start = ign && (t == 1);
          if (start) begin seed = 8'($urandom); count = 8'($urandom); end
        end
      end
    end
    wait_done(done_base + 1, dc, ok);
    if (ok) begin
      if (cnt == 0) chk("count=0 done latency", dc - s_cyc, 2);
      if (tmo) chk("timeout done latency", dc - tc, TMO + 1);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset(input logic [7:0] sd);
    int tc, d0;
    bit ok;
    tx_q.push_back(sd);
    d0 = done_cnt;
    tick(); start = 1'b1; seed = sd; count = 8'd3;
    tick(); start = 1'b0;
    wait_tx(tx_cnt + 1, tc, ok);
    repeat (5) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst tx_start", tx_start, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst timeout", timeout, 0);
    chk("rst err_count", err_count, 0);
    chk("rst last_rx", last_rx, 0);
    last_model = 8'h00;
    repeat (80) tick();
    chk("no done after reset abort", done_cnt, d0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    @(negedge clk);
    chk("reset tx_start", tx_start, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    chk("reset timeout", timeout, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset err_count", err_count, 0);
    chk("reset last_rx", last_rx, 0);
    tick(); rst = 1'b0;
    repeat (2) tick();

    do_run(8'h10, 3, 0, -1, 0, 0, 0, 50, 0);   // clean echo, 50-cycle delay
    do_run(8'hFE, 2, 1, -1, 0, 0, 0, 0, 0);    // unchanged echo -> 2 errors
    do_run(8'hFF, 2, 0, 1, 0, 0, 0, 0, 0);     // wrap echo then timeout
    do_run(8'h40, 4, 0, -1, 1, 0, 1, 0, 5);    // long valid + stray edge + ignored start
    do_run(8'h77, 0, 0, -1, 0, 0, 0, 0, 0);    // empty run
    do_run(8'h20, 2, 0, -1, 0, 0, 0, 63, 1);   // echo on last allowed cycle
    do_run(8'h30, 4, 0, -1, 0, 1, 0, 0, 0);    // no tx_busy: latency checks
    test_reset(8'h55);
    do_run(8'h60, 3, 0, -1, 0, 0, 0, 0, 0);    // normal run after reset abort

    for (int n = 0; n < 20; n++) begin
      int cnt, drop;
      bit nb;
      cnt  = int'($urandom_range(0, 8));
      drop = ($urandom_range(4) == 0) ? int'($urandom_range(0, cnt)) : -1;
      nb   = ($urandom_range(3) == 0);
      do_run(8'($urandom), cnt, int'($urandom_range(0, 2)), drop,
             1'($urandom_range(1)), nb, 1'($urandom_range(1)), 0, 0);
    end

    repeat (5) tick();
    chk("tx queue drained", tx_q.size(), 0);
    chk("result queue drained", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_echo_initiator.md
UART_ECHO_INITIATOR -- requirements
Module: uart_echo_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles to wait for an echo after each tx_start.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a test run.
REQ-005 SHALL have port seed, input, 8: first byte sent; sampled when start is accepted.
REQ-006 SHALL have port count, input, 8: number of transactions in the run; sampled when start is accepted.
REQ-007 SHALL have port tx_data, output, 8: byte to the uart_tx instance.
REQ-008 SHALL have port tx_start, output, 1: one-cycle transmit strobe to uart_tx.
REQ-009 SHALL have port tx_busy, input, 1: uart_tx busy flag.
REQ-010 SHALL have port rx_data, input, 8: byte from the uart_rx instance.
REQ-011 SHALL have port rx_valid, input, 1: uart_rx valid flag, level, may stay high several cycles.
REQ-012 SHALL have port busy, output, 1: high while a run is in progress (state not IDLE).
REQ-013 SHALL have port done, output, 1: one-cycle pulse at end of run.
REQ-014 SHALL have port pass, output, 1: run result, valid from done until next accepted start.
REQ-015 SHALL have port timeout, output, 1: run aborted on missing echo.
REQ-016 SHALL have port err_count, output, 8: mismatched echoes in the run, saturating.
REQ-017 SHALL have port last_rx, output, 8: most recent byte captured on a valid edge in WAIT_RX.

Function
REQ-018 SHALL implement states IDLE, SEND, WAIT_RX, CHECK, DONE.
REQ-019 IDLE: start=1 SHALL latch seed into tx_data and count into a remaining counter, and clear pass, timeout and err_count; the next state SHALL be SEND, or DONE if count=0.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 SEND: while tx_busy=1 the block SHALL hold in SEND; when tx_busy=0 it SHALL assert tx_start for exactly one cycle, clear the timeout counter and go to WAIT_RX.
REQ-022 tx_data SHALL stay stable from the SEND entry until the next byte update in CHECK.
REQ-023 The echo event SHALL be the rx_valid rising edge (rx_valid & ~rx_valid_d); rx_valid_d SHALL register rx_valid every cycle in all states.
REQ-024 Edges outside WAIT_RX SHALL be ignored: no capture, no count.
REQ-025 WAIT_RX: an edge SHALL capture rx_data into last_rx and go to CHECK.
REQ-026 WAIT_RX: the timeout counter SHALL increment each cycle without an edge; when it reaches TIMEOUT_CYCLES-1 the block SHALL set timeout=1 and go to DONE.
REQ-027 An edge in the same cycle as the timeout condition SHALL win, with no timeout.
REQ-028 CHECK (1 cycle): if last_rx != (tx_data+1) mod 256, err_count SHALL increment, saturating at 255.
REQ-029 CHECK: remaining SHALL decrement; if it becomes 0 the next state SHALL be DONE, otherwise tx_data SHALL become (tx_data+1) mod 256 and the next state SHALL be SEND.
REQ-030 An expected echo of 0x00 for tx_data 0xFF SHALL be legal.
REQ-031 DONE (1 cycle): done SHALL be 1, pass SHALL be set to (err_count==0 && timeout==0), and the next state SHALL be IDLE.
REQ-032 pass, timeout, err_count and last_rx SHALL hold their values in IDLE until the next accepted start; last_rx SHALL NOT be cleared by start.
REQ-033 Latency SHALL be: start to first tx_start = 2 cycles when tx_busy=0; echo edge to next tx_start = 3 cycles (CHECK, SEND) when tx_busy=0.

Reset
REQ-034 When rst=1 on a clk edge, the block SHALL go to IDLE, and tx_start, done, pass, timeout, busy and rx_valid_d SHALL be 0.
REQ-035 When rst=1 on a clk edge, tx_data, err_count, last_rx, the remaining counter and the timeout counter SHALL be 0.
REQ-036 rst SHALL take priority over every other input, including in the middle of a run; no done pulse SHALL be produced for an aborted run.

Verification
REQ-037 Loopback model echoes byte+1 after 50 cycles; seed=0x10, count=3 -> tx bytes 0x10, 0x11, 0x12; done pulse; pass=1; err_count=0; last_rx=0x13.
REQ-038 Model echoes byte unchanged; seed=0xFE, count=2 -> err_count=2, pass=0, timeout=0.
REQ-039 Model echoes byte+1 but never the second byte; TIMEOUT_CYCLES=16, seed=0xFF, count=2 -> first echo 0x00 accepted; timeout=1 after 16 WAIT_RX cycles; pass=0; done pulse.
REQ-040 Hold rx_valid high 5 cycles per echo, plus a stray edge during SEND -> each echo counted once, stray ignored, pass=1.
REQ-041 count=0 -> no tx_start; done 2 cycles after start; pass=1.
REQ-042 Pulse rst in WAIT_RX -> all outputs 0 next cycle; no done pulse; a following start runs normally.
